striping_sched: RTL
===================

# striping_sched

Lane scheduler for the PCIe physical-layer transmit striping path, running in the `clk_2f` domain. It accepts a word stream from the upstream buffer through a ready/valid handshake and assigns each word round-robin to one of four lanes, honouring the configured link width (x1/x2/x4). It inserts a SKP ordered-set cycle on all active lanes at stripe boundaries every `SKP_INTERVAL` words. Width changes take effect only while the link is idle.

## Interface
- `DATA_W`, 32, word width per lane.
- `SKP_INTERVAL`, 16, accepted words between SKP insertions; 0 disables SKP.
- `SKP_SYM`, 32'h1C1C_1C1C, word driven on active lanes during a SKP cycle.
- `clk_2f`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `cfg_width`  in  2  00=x1 (lane 0), 01=x2 (lanes 0-1), 10/11=x4 (lanes 0-3).
- `in_data`  in  DATA_W  upstream word.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  scheduler accepts a word this cycle (combinational).
- `lane_data`  out  4*DATA_W  lane n occupies bits [n*DATA_W +: DATA_W]; registered.
- `lane_valid`  out  4  per-lane word strobe; registered.
- `lane_skp`  out  1  current lane outputs carry `SKP_SYM`; registered.
- `stripe_ptr`  out  2  lane that receives the next accepted word.
- `link_active`  out  1  FSM not in IDLE.

## Operation
- A word is accepted when `in_valid` and `in_ready` are both 1 at a rising edge. `in_ready` = 1 when `reset` = 1 and the state is not SKP.
- Active width register `act_w`:
  - Loads `cfg_width` at every edge while the state is IDLE, including the edge on which IDLE exits.
  - Holds in RUN and SKP.
  - `cfg_width` changes during RUN/SKP are ignored until the next IDLE.
  - N = 1, 2 or 4 active lanes.
- FSM states:
  - IDLE: an accept sends the word to lane 0; next state RUN.
  - RUN: an accept sends the word to lane `stripe_ptr`; `stripe_ptr` advances modulo N.
    - Go to SKP if, after the accept, `SKP_INTERVAL` ≠ 0, `word_cnt` ≥ `SKP_INTERVAL` and the new `stripe_ptr` = 0.
    - Go to IDLE if no accept and `stripe_ptr` = 0.
    - Otherwise stay in RUN.
    - A partial stripe (`stripe_ptr` ≠ 0) with `in_valid` = 0 waits in RUN indefinitely; no padding is inserted.
  - SKP: lasts exactly one cycle, always followed by RUN. On its closing edge: `lane_data` of active lanes = `SKP_SYM`, `lane_valid` of active lanes = 1, inactive lanes' valid = 0, `lane_skp` = 1, and `word_cnt` is cleared.
- `word_cnt`:
  - Width is clog2(`SKP_INTERVAL`+1).
  - Increments on every accept and saturates at `SKP_INTERVAL`.
  - Holds in IDLE; is not cleared by IDLE.
- Lane output register update, on every edge:
  - `lane_valid` and `lane_skp` default to 0.
  - On an accept, only the selected lane's data and valid are written.
  - Non-selected lanes hold their last data with valid 0.
- Reset (asynchronous, at any time, including mid-stripe or in SKP):
  - State IDLE; `stripe_ptr` = 0; `word_cnt` = 0; `act_w` = 00.
  - `lane_data` = 0; `lane_valid` = 0; `lane_skp` = 0; `link_active` = 0; `in_ready` = 0.
  - Any in-flight partial stripe is discarded.

## Timing
- Latency: a word accepted at edge t appears on its lane with `lane_valid` high during the cycle after t, for exactly one cycle.
- Throughput: one word per cycle in RUN; no bubble on the IDLE→RUN transition.
- SKP sequence, with the stripe-completing word accepted at edge t:
  - State is SKP during the cycle after t; `in_ready` = 0 in that cycle.
  - The SKP pattern is on the lanes in the following cycle (t+2).
  - The next accept can occur at edge t+2.
- `stripe_ptr`, `link_active` and `in_ready` reflect the current state; no added delay.

## Test plan
- Reset: drive `reset` = 0 mid-run with `lane_valid` = 4'b0010 → all outputs 0 and `in_ready` = 0 asynchronously, before the next edge. Release, then accept one word → it lands on lane 0.
- x2 streaming, `SKP_INTERVAL` = 0: words A0..A3 on consecutive cycles → lane 0 gets A0 then A2, lane 1 gets A1 then A3; `lane_valid` = 01,10,01,10; `in_ready` stays 1; IDLE one cycle after A3 is accepted.
- x4 gap mid-stripe: accept B0, B1, then hold `in_valid` = 0 for 5 cycles, then accept B2, B3 → `stripe_ptr` = 2 and `link_active` = 1 throughout the gap; B2 on lane 2, B3 on lane 3.
- SKP insertion, x2, `SKP_INTERVAL` = 4, 6 continuous words → `in_ready` = 0 for exactly the cycle after the 4th accept; next cycle lanes 0 and 1 = 32'h1C1C_1C1C with `lane_valid` = 0011 and `lane_skp` = 1; words 5 and 6 then go to lanes 0 and 1.
- SKP deferred to stripe boundary, x4, `SKP_INTERVAL` = 2, 4 words → no SKP after word 2; SKP occurs only after word 4, with `lane_valid` = 1111.
- Width change: start x1, switch `cfg_width` to 10 after the 2nd of 3 words → all 3 words on lane 0. After return to IDLE, the next 4 words go to lanes 0-3.

Source files
------------

// File: rtl/striping_sched.sv
// rtl/striping_sched.sv - round-robin lane scheduler with periodic SKP insertion
module striping_sched #(
  parameter int                DATA_W       = 32,
  parameter int                SKP_INTERVAL = 16,
  parameter logic [DATA_W-1:0] SKP_SYM      = DATA_W'(32'h1C1C_1C1C)
) (
  input  logic                clk_2f,
  input  logic                reset,
  input  logic [1:0]          cfg_width,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DATA_W-1:0] lane_data,
  output logic [3:0]          lane_valid,
  output logic                lane_skp,
  output logic [1:0]          stripe_ptr,
  output logic                link_active
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SKP  = 2'd2;

  // A zero interval still needs a one-bit counter so the logic stays well formed.
  localparam int             CNT_W   = (SKP_INTERVAL == 0) ? 1 : $clog2(SKP_INTERVAL + 1);
  localparam logic [CNT_W-1:0] SKP_MAX = CNT_W'(SKP_INTERVAL);

  logic [1:0]       state, state_nx;
  logic [1:0]       act_w;
  logic [1:0]       width_eff;
  logic [1:0]       ptr_q, ptr_nx, ptr_adv;
  logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc;
  logic [3:0]       lane_mask;
  logic             accept;
  logic             skp_due;

  assign in_ready    = reset && (state != ST_SKP);
  assign accept      = in_valid && in_ready;
  assign link_active = (state != ST_IDLE);
  assign stripe_ptr  = ptr_q;

  // While idle the incoming configuration is already the one the first word uses.
  assign width_eff = (state == ST_IDLE) ? cfg_width : act_w;
  assign cnt_inc   = (cnt_q == SKP_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign skp_due   = (SKP_INTERVAL != 0) && (cnt_inc == SKP_MAX) && (ptr_adv == 2'd0);

  // Active lane mask and stripe pointer advance for the effective width.
  always_comb begin
    lane_mask = 4'b1111;
    ptr_adv   = ptr_q + 2'd1;
    case (width_eff)
      2'b00: begin
        lane_mask = 4'b0001;
        ptr_adv   = 2'd0;
      end
      2'b01: begin
        lane_mask = 4'b0011;
        ptr_adv   = {1'b0, ~ptr_q[0]};
      end
      default: ;
    endcase
  end

  // Next-state logic for the FSM, stripe pointer and interval counter.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_RUN;
          ptr_nx   = ptr_adv;
          cnt_nx   = cnt_inc;
        end
      end
      ST_RUN: begin
        if (accept) begin
          ptr_nx = ptr_adv;
          cnt_nx = cnt_inc;
          if (skp_due) state_nx = ST_SKP;
        end else if (ptr_q == 2'd0) begin
          state_nx = ST_IDLE;
        end
      end
      ST_SKP: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control state registers; the width is sampled only while idle.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ptr_q <= 2'd0;
      cnt_q <= '0;
      act_w <= 2'b00;
    end else begin
      state <= state_nx;
      ptr_q <= ptr_nx;
      cnt_q <= cnt_nx;
      if (state == ST_IDLE) act_w <= cfg_width;
    end
  end

  // Lane output registers: strobes are single-cycle, data holds between writes.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      lane_data  <= '0;
      lane_valid <= 4'b0000;
      lane_skp   <= 1'b0;
    end else begin
      lane_valid <= 4'b0000;
      lane_skp   <= 1'b0;
      if (state == ST_SKP) begin
        for (int n = 0; n < 4; n++) begin
          if (lane_mask[n]) lane_data[n*DATA_W +: DATA_W] <= SKP_SYM;
        end
        lane_valid <= lane_mask;
        lane_skp   <= 1'b1;
      end else if (accept) begin
        lane_data[ptr_q*DATA_W +: DATA_W] <= in_data;
        lane_valid                        <= 4'b0001 << ptr_q;
      end
    end
  end

endmodule
